// File: rtl/tx_feeder.sv
// ---------------------------------------------------------------------------
// tx_feeder
//
// Purpose:
//   Transmit-side frame feeder. A one-cycle start pulse (btn_tick) causes the
//   block to read N_BYTES bytes from a synchronous buffer RAM (one cycle read
//   latency). Each byte is pushed into the UART TX FIFO with a single write
//   strobe. No write is ever issued while the FIFO reports full.
//
//   Per-byte sequence: FETCH (address stable, RAM read in flight) ->
//   LOAD (capture rd_data into w_data) -> PUSH (strobe when not full).
//   When the FIFO is never full this is 3 cycles per byte, and the frame
//   latency from btn_tick to done_tick is 3*N_BYTES+1 cycles.
//
// Optional feature (macro TX_FEEDER_CHECKSUM_EN):
//   An 8-bit running XOR of every written byte (low 8 bits of w_data) is
//   appended to the frame as one extra byte. This adds the states CSUM (load
//   the checksum into w_data) and CSUM_WR (write it under the same full rule
//   as PUSH). The frame is then N_BYTES+1 writes and the latency is
//   3*N_BYTES+3 cycles. This build requires DATA_W >= 8.
//
// Parameters:
//   DATA_W   byte width of the buffer data and the FIFO write data
//   ADDR_W   buffer address width
//   N_BYTES  frame length in bytes, 1..2**ADDR_W
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   btn_tick   in   one-cycle start pulse; accepted only in IDLE
//   tx_full    in   TX FIFO full flag
//   rd_addr    out  buffer read address (ADDR_W)
//   rd_data    in   buffer read data, valid one clk after rd_addr (DATA_W)
//   w_data     out  registered byte to the TX FIFO (DATA_W)
//   wr_uart    out  FIFO write strobe, one cycle per byte
//   busy       out  high in every state except IDLE
//   done_tick  out  one-cycle pulse after the last byte is written
// ---------------------------------------------------------------------------
module tx_feeder #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int N_BYTES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_tick,
  input  logic              tx_full,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] w_data,
  output logic              wr_uart,
  output logic              busy,
  output logic              done_tick
);

  // Address of the final byte. For N_BYTES = 2**ADDR_W this is all ones, and
  // the increment is never taken from it, so the address never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_BYTES - 1);

`ifdef TX_FEEDER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    PUSH    = 3'd3,
    DONE    = 3'd4,
    CSUM    = 3'd5,
    CSUM_WR = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PUSH  = 3'd3,
    DONE  = 3'd4
  } state_t;
`endif

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic [DATA_W-1:0] w_data_reg, w_data_next;

`ifdef TX_FEEDER_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      rd_addr_reg <= '0;
      w_data_reg  <= '0;
`ifdef TX_FEEDER_CHECKSUM_EN
      csum_reg    <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      rd_addr_reg <= rd_addr_next;
      w_data_reg  <= w_data_next;
`ifdef TX_FEEDER_CHECKSUM_EN
      csum_reg    <= csum_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath update logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    rd_addr_next = rd_addr_reg;
    w_data_next  = w_data_reg;
`ifdef TX_FEEDER_CHECKSUM_EN
    csum_next    = csum_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (btn_tick) begin
          rd_addr_next = '0;
`ifdef TX_FEEDER_CHECKSUM_EN
          csum_next    = '0;
`endif
          state_next   = FETCH;
        end
      end

      // Address is held; the RAM read issued here is captured in LOAD.
      FETCH: begin
        state_next = LOAD;
      end

      LOAD: begin
        w_data_next = rd_data;
        state_next  = PUSH;
      end

      // A full FIFO simply stalls here with w_data and rd_addr untouched,
      // so no byte is lost or duplicated.
      PUSH: begin
        if (!tx_full) begin
`ifdef TX_FEEDER_CHECKSUM_EN
          csum_next = csum_reg ^ w_data_reg[7:0];
`endif
          if (rd_addr_reg == LAST_ADDR) begin
`ifdef TX_FEEDER_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end else begin
            rd_addr_next = rd_addr_reg + 1'b1;
            state_next   = FETCH;
          end
        end
      end

`ifdef TX_FEEDER_CHECKSUM_EN
      // The checksum already includes the last data byte (folded in on the
      // PUSH write), so it can be loaded directly.
      CSUM: begin
        w_data_next = DATA_W'(csum_reg);
        state_next  = CSUM_WR;
      end

      CSUM_WR: begin
        if (!tx_full) begin
          state_next = DONE;
        end
      end
`endif

      // btn_tick is deliberately not looked at here: a new frame needs a
      // fresh pulse once back in IDLE.
      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic (Moore on state; the write strobe is qualified by !tx_full)
  // -------------------------------------------------------------------------
  always_comb begin
    wr_uart   = 1'b0;
    done_tick = 1'b0;
    busy      = (state_reg != IDLE);

    // Strobes are gated by reset so an abandoned frame never emits a
    // write or a completion pulse in the reset cycle itself.
    if (!reset) begin
      case (state_reg)
        PUSH:    wr_uart   = !tx_full;
`ifdef TX_FEEDER_CHECKSUM_EN
        CSUM_WR: wr_uart   = !tx_full;
`endif
        DONE:    done_tick = 1'b1;
        default: begin
          wr_uart   = 1'b0;
          done_tick = 1'b0;
        end
      endcase
    end
  end

  assign rd_addr = rd_addr_reg;
  assign w_data  = w_data_reg;

endmodule

// File: tb/tb_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_tx_feeder
//
// Scoreboard bench for tx_feeder with ADDR_W=2, N_BYTES=4 so every frame
// spans the full address range. Expected bytes (data, address, write cycle)
// and expected done_tick cycles are queued when a frame is started and are
// popped by a monitor that samples the DUT on the falling clock edge.
// Defining TX_FEEDER_CHECKSUM_EN for both files exercises the checksum build.
// ---------------------------------------------------------------------------
module tb_tx_feeder;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int N      = 4;
`ifdef TX_FEEDER_CHECKSUM_EN
  localparam int DONE_LAT = 3 * N + 3;
`else
  localparam int DONE_LAT = 3 * N + 1;
`endif

  logic              clk;
  logic              reset;
  logic              btn_tick;
  logic              tx_full;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] w_data;
  logic              wr_uart;
  logic              busy;
  logic              done_tick;

  tx_feeder #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .N_BYTES(N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_tick (btn_tick),
    .tx_full  (tx_full),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .w_data   (w_data),
    .wr_uart  (wr_uart),
    .busy     (busy),
    .done_tick(done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer RAM model with one-cycle registered read.
  logic [DATA_W-1:0] mem [N];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int   exp_done[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pulse btn_tick for one cycle; b is the cycle in which it is high.
  task automatic start_frame(output int b);
    @(posedge clk);
    #1 btn_tick = 1'b1;
    b = cyc;
    @(posedge clk);
    #1 btn_tick = 1'b0;
  endtask

  // Queue the expected writes of one frame. Writes from index stall_at on
  // are delayed by stall_len cycles of FIFO-full.
  task automatic expect_frame(input int b, input int stall_at, input int stall_len);
    exp_t       e;
    logic [7:0] x;
    int         d;
    x = '0;
    for (int i = 0; i < N; i++) begin
      d      = (i >= stall_at) ? stall_len : 0;
      e.data = mem[i];
      e.addr = ADDR_W'(i);
      e.cyc  = b + 3 + 3 * i + d;
      sb.push_back(e);
      x = x ^ mem[i];
    end
    d = (stall_at < N) ? stall_len : 0;
`ifdef TX_FEEDER_CHECKSUM_EN
    e.data = x;
    e.addr = ADDR_W'(N - 1);
    e.cyc  = b + 3 * N + 2 + d;
    sb.push_back(e);
`endif
    exp_done.push_back(b + DONE_LAT + d);
  endtask

  // Monitor: one line per observed transaction, checks against the queues.
  initial begin
    exp_t e;
    int   dc;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) check("busy_after_done", busy, 0);
      prev_done = done_tick;
      if (wr_uart) begin
        $display("cycle %0d: write addr=%0d data=0x%02h", cyc, rd_addr, w_data);
        check("wr_while_full", tx_full, 0);
        check("busy_on_wr", busy, 1);
        if (sb.size() == 0) begin
          check("unexpected_wr", wr_uart, 0);
        end else begin
          e = sb.pop_front();
          check("wr_data", w_data, e.data);
          check("wr_addr", rd_addr, e.addr);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      if (done_tick) begin
        $display("cycle %0d: done_tick addr=%0d", cyc, rd_addr);
        check("busy_on_done", busy, 1);
        check("done_addr_hold", rd_addr, N - 1);
        if (exp_done.size() == 0) begin
          check("unexpected_done", done_tick, 0);
        end else begin
          dc = exp_done.pop_front();
          check("done_cycle", cyc, dc);
        end
      end
    end
  end

  initial begin
    int b;
    reset    = 1'b1;
    btn_tick = 1'b0;
    tx_full  = 1'b0;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wr", wr_uart, 0);
    check("rst_done", done_tick, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_wdata", w_data, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic frame
    start_frame(b);
    expect_frame(b, 99, 0);
    repeat (DONE_LAT + 3) @(posedge clk);

    // Backpressure: full rises as the 2nd PUSH is entered, held 10 cycles
    start_frame(b);
    expect_frame(b, 1, 10);
    repeat (5) @(posedge clk);
    #1 tx_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_wdata_hold", w_data, 8'h22);
      check("bp_no_wr", wr_uart, 0);
      check("bp_busy", busy, 1);
    end
    @(posedge clk);
    #1 tx_full = 1'b0;
    repeat (DONE_LAT + 5) @(posedge clk);

    // Ignored start: pulses at the 5th frame cycle and in the DONE cycle
    start_frame(b);
    expect_frame(b, 99, 0);
    repeat (4) @(posedge clk);
    #1 btn_tick = 1'b1;
    @(posedge clk);
    #1 btn_tick = 1'b0;
    repeat (DONE_LAT - 6) @(posedge clk);
    #1 btn_tick = 1'b1;
    check("btn_in_done", done_tick, 1);
    @(posedge clk);
    #1 btn_tick = 1'b0;
    repeat (25) @(posedge clk);
    check("ign_sb_empty", sb.size(), 0);

    // Mid-frame reset after the 2nd write
    start_frame(b);
    expect_frame(b, 99, 0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
`ifdef TX_FEEDER_CHECKSUM_EN
    check("rst_after_2nd", sb.size(), N - 1);
`else
    check("rst_after_2nd", sb.size(), N - 2);
`endif
    sb.delete();
    exp_done.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_wr", wr_uart, 0);
      check("midrst_done", done_tick, 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_addr", rd_addr, 0);
      check("post_rst_wr", wr_uart, 0);
    end
    start_frame(b);
    expect_frame(b, 99, 0);
    repeat (DONE_LAT + 3) @(posedge clk);

    // Random data
    for (int i = 0; i < N; i++) mem[i] = DATA_W'($urandom);
    start_frame(b);
    expect_frame(b, 99, 0);
    repeat (DONE_LAT + 3) @(posedge clk);

    // Short stall on the last data byte
    start_frame(b);
    expect_frame(b, 3, 3);
    repeat (11) @(posedge clk);
    #1 tx_full = 1'b1;
    repeat (3) @(posedge clk);
    #1 tx_full = 1'b0;
    repeat (DONE_LAT + 8) @(posedge clk);

    check("sb_empty", sb.size(), 0);
    check("done_q_empty", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_feeder.md
Name: tx_feeder

Overview:
- Transmit-side counterpart of the RX drain logic. On a debounced button tick it reads a fixed-length frame of bytes from a synchronous buffer RAM and pushes them one at a time into the UART TX FIFO.
- One write pulse per byte; never writes while the FIFO reports full.
- Sits between the image-processing result buffer and the UART transmitter FIFO.

Parameters:
- DATA_W, 8, byte width of buffer data and FIFO write data.
- ADDR_W, 8, buffer address width.
- N_BYTES, 16, frame length in bytes; legal range 1..2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk.
- btn_tick  input  1  one-cycle start pulse from the debouncer.
- tx_full  input  1  TX FIFO full flag.
- rd_addr  output  ADDR_W  buffer read address.
- rd_data  input  DATA_W  buffer read data; valid one clk after rd_addr.
- w_data  output  DATA_W  registered byte to the TX FIFO.
- wr_uart  output  1  FIFO write strobe; one cycle per byte.
- busy  output  1  high in every state except IDLE.
- done_tick  output  1  one-cycle pulse after the last byte is written.

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, rd_addr=0, w_data=0.
- Reset values of outputs: wr_uart=0, busy=0, done_tick=0.
- While reset=1, wr_uart and done_tick are gated to 0 combinationally.
- States: IDLE, FETCH, LOAD, PUSH, DONE.
- IDLE: on btn_tick, rd_addr<=0 and go to FETCH. Otherwise hold.
- FETCH: rd_addr is held stable. Next state is LOAD (covers the 1-cycle RAM latency).
- LOAD: w_data<=rd_data. Next state is PUSH.
- PUSH with tx_full=0:
  - wr_uart=1 this cycle (Moore on state, qualified by !tx_full).
  - If rd_addr==N_BYTES-1, go to DONE.
  - Otherwise rd_addr<=rd_addr+1 and go to FETCH.
- PUSH with tx_full=1: wr_uart=0, hold PUSH. w_data and rd_addr stay stable.
- DONE: done_tick=1 for exactly one cycle, then go to IDLE.
- Throughput: 3 cycles per byte when the FIFO is not full. Frame latency from btn_tick to done_tick is 3*N_BYTES+1 cycles.
- btn_tick in any state other than IDLE is ignored (not queued).
- btn_tick in the same cycle as DONE is ignored. A new frame needs btn_tick while in IDLE.
- Address arithmetic is ADDR_W wide, with no wrap within a frame.
  - N_BYTES=2**ADDR_W ends at the all-ones address.
  - The increment is never taken from the last address.
- Reset mid-frame: abandon the frame immediately. There is no partial-frame done_tick, and the next frame restarts at address 0.
- tx_full rising in the same cycle the FSM enters PUSH: no write happens; the FSM waits.

Optional Feature:
- Macro: TX_FEEDER_CHECKSUM_EN.
- When defined:
  - An 8-bit running XOR (low 8 bits of w_data) accumulates every written byte; it is cleared on btn_tick accept and on reset.
  - After the last data byte, the FSM enters state CSUM instead of DONE.
  - CSUM loads w_data<=checksum and writes it under the same tx_full rule as PUSH, then goes to DONE.
  - Frame becomes N_BYTES+1 writes; latency is 3*N_BYTES+3 cycles.
- When undefined: the CSUM state and the checksum register are absent, and behaviour is exactly as above.

Test Plan:
- Basic frame: N_BYTES=4, RAM holds 0x11,0x22,0x33,0x44, tx_full=0, one btn_tick.
  - Exactly 4 wr_uart pulses with w_data 0x11,0x22,0x33,0x44, 3 cycles apart.
  - done_tick 13 cycles after btn_tick; busy falls with it.
- Backpressure: as above, but hold tx_full=1 for 10 cycles upon reaching the 2nd PUSH.
  - No wr_uart while full; w_data stays 0x22.
  - Write occurs the first cycle tx_full=0; no byte is lost or duplicated.
- Ignored start: pulse btn_tick again at the 5th cycle of a frame.
  - Single frame of 4 writes, single done_tick, no second frame.
- Mid-frame reset: assert reset after the 2nd write, then issue btn_tick.
  - wr_uart=0 during and after reset, no done_tick.
  - New frame starts at rd_addr=0 with the 0x11 byte.
- Full address span: ADDR_W=2, N_BYTES=4.
  - rd_addr sequence 0,1,2,3.
  - No increment past 3; rd_addr holds 3 in DONE.
- Checksum (TX_FEEDER_CHECKSUM_EN): data 0x11,0x22,0x33,0x44.
  - 5 writes, the 5th w_data=0x44 (XOR of the four bytes).
  - done_tick 15 cycles after btn_tick.
